// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA opcodes, HALT sentinel and fetch FSM encoding
package isa_pkg;

    // 6-bit opcodes carried in instr[31:26]
    localparam logic [5:0] OP_ADD         = 6'b000001;
    localparam logic [5:0] OP_SUB         = 6'b000010;
    localparam logic [5:0] OP_INC         = 6'b000011;
    localparam logic [5:0] OP_DEC         = 6'b000100;
    localparam logic [5:0] OP_AND         = 6'b000101;
    localparam logic [5:0] OP_OR          = 6'b000110;
    localparam logic [5:0] OP_XOR         = 6'b000111;
    localparam logic [5:0] OP_NOT         = 6'b001000;
    localparam logic [5:0] OP_SHIFT_LEFT  = 6'b001001;
    localparam logic [5:0] OP_SHIFT_RIGHT = 6'b001010;
    localparam logic [5:0] OP_LW          = 6'b100010;
    localparam logic [5:0] OP_SW          = 6'b100100;

    // Opcode 000000 is unused by the ISA, so the all-zero word ends a program
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instr_rom_wr.sv
// rtl/instr_rom_wr.sv - DEPTHx32 instruction store, sync write, async read
//
// Ports:
//   clk     - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - combinational read data
module instr_rom_wr #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    // Contents are deliberately not reset; the loader owns them
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - programmable instruction store sequenced to the datapath
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   load_en/addr/data - loader write port (honoured in IDLE or HALT)
//   start             - begin fetch at pc=0 (honoured in IDLE or HALT)
//   abort             - return to IDLE from any state
//   instr/instr_valid - registered instruction and valid toward the datapath
//   instr_ready       - consumer accepts instr this cycle
//   pc                - address of the word on instr
//   busy, done        - in RUN, in HALT
//   issued            - accepted instructions since the last start
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter logic [31:0] HALT_WORD = isa_pkg::HALT_WORD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          abort,
    output logic [31:0]   instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   issued
);

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [31:0]   r_instr;
    logic [31:0]   w_instr_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic [AW:0]   r_issued;
    logic [AW:0]   w_issued_nxt;

    logic          w_ctrl_open;
    logic          w_start_go;
    logic          w_mem_we;
    logic [AW-1:0] w_rd_addr;
    logic [31:0]   w_rd_data;
    logic [31:0]   w_fetch_word;
    logic          w_xfer;

    // Loads and start are only accepted outside RUN; abort overrides both
    assign w_ctrl_open = (r_state != ST_RUN);
    assign w_start_go  = start && w_ctrl_open && !abort;
    assign w_mem_we    = load_en && w_ctrl_open && !abort;
    assign w_xfer      = r_valid && instr_ready;

    // Start fetches word 0; otherwise prefetch the successor of pc
    assign w_rd_addr = w_start_go ? '0 : r_pc + 1'b1;

    instr_rom_wr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rom (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // A load issued with start lands first, so forward it to the fetched word
    assign w_fetch_word = (w_mem_we && (load_addr == w_rd_addr)) ? load_data : w_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_issued <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_valid  <= w_valid_nxt;
            r_issued <= w_issued_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_valid_nxt  = r_valid;
        w_issued_nxt = r_issued;

        if (abort) begin
            // issued is kept so software can see how far the run got
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = '0;
            w_instr_nxt = '0;
            w_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (w_start_go) begin
                        w_pc_nxt     = '0;
                        w_instr_nxt  = w_fetch_word;
                        w_issued_nxt = '0;
                        if (w_fetch_word == HALT_WORD) begin
                            w_state_nxt = ST_HALT;
                            w_valid_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_RUN;
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        w_issued_nxt = r_issued + 1'b1;
                        if (r_pc == LAST_PC) begin
                            // No wrap-around past the last word
                            w_state_nxt = ST_HALT;
                            w_valid_nxt = 1'b0;
                        end else if (w_fetch_word == HALT_WORD) begin
                            w_state_nxt = ST_HALT;
                            w_valid_nxt = 1'b0;
                            w_pc_nxt    = r_pc + 1'b1;
                        end else begin
                            w_pc_nxt    = r_pc + 1'b1;
                            w_instr_nxt = w_fetch_word;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                    w_instr_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign issued      = r_issued;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] W_LW  = 32'h8820_0001;
    localparam logic [31:0] W_ADD = 32'h0401_1800;
    localparam logic [31:0] W_INC = 32'h0C00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [4:0]  issued;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(16), .AW(4), .HALT_WORD(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .abort       (abort),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .issued      (issued)
    );

    typedef struct {
        logic        ld;
        logic [3:0]  la;
        logic [31:0] ldat;
        logic        st;
        logic        ab;
        logic        rdy;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [3:0]  e_pc;
        logic        e_busy;
        logic        e_done;
        logic [4:0]  e_issued;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic ld, input logic [3:0] la, input logic [31:0] ldat,
                                input logic st, input logic ab, input logic rdy,
                                input logic [31:0] ei, input logic ev, input logic [3:0] epc,
                                input logic eb, input logic ed, input logic [4:0] eiss);
        vec_t v;
        v.ld = ld; v.la = la; v.ldat = ldat; v.st = st; v.ab = ab; v.rdy = rdy;
        v.e_instr = ei; v.e_valid = ev; v.e_pc = epc;
        v.e_busy = eb; v.e_done = ed; v.e_issued = eiss;
        return v;
    endfunction

    task automatic check_out(input string name, input logic [31:0] ei, input logic ev,
                             input logic [3:0] epc, input logic eb, input logic ed,
                             input logic [4:0] eiss);
        n_checks++;
        if ({instr, instr_valid, pc, busy, done, issued} === {ei, ev, epc, eb, ed, eiss}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got instr=%h valid=%b pc=%0d busy=%b done=%b issued=%0d, want instr=%h valid=%b pc=%0d busy=%b done=%b issued=%0d",
                     name, instr, instr_valid, pc, busy, done, issued, ei, ev, epc, eb, ed, eiss);
        end
    endtask

    task automatic drive(input logic ld, input logic [3:0] la, input logic [31:0] ldat,
                         input logic st, input logic ab, input logic rdy);
        load_en = ld; load_addr = la; load_data = ldat;
        start = st; abort = ab; instr_ready = rdy;
        @(posedge clk);
        #1;
        load_en = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        // Program A: LW, ADD, HALT
        vecs[0]  = mk(1, 4'd0, W_LW,  0, 0, 1, 32'h0, 0, 4'd0, 0, 0, 5'd0);
        vecs[1]  = mk(1, 4'd1, W_ADD, 0, 0, 1, 32'h0, 0, 4'd0, 0, 0, 5'd0);
        vecs[2]  = mk(1, 4'd2, 32'h0, 0, 0, 1, 32'h0, 0, 4'd0, 0, 0, 5'd0);
        vecs[3]  = mk(0, 4'd0, 32'h0, 1, 0, 1, W_LW,  1, 4'd0, 1, 0, 5'd0);
        vecs[4]  = mk(0, 4'd0, 32'h0, 0, 0, 1, W_ADD, 1, 4'd1, 1, 0, 5'd1);
        vecs[5]  = mk(0, 4'd0, 32'h0, 0, 0, 1, W_ADD, 0, 4'd2, 0, 1, 5'd2);
        vecs[6]  = mk(0, 4'd0, 32'h0, 0, 0, 1, W_ADD, 0, 4'd2, 0, 1, 5'd2);
        // Restart from HALT with back-pressure for three cycles
        vecs[7]  = mk(0, 4'd0, 32'h0, 1, 0, 0, W_LW,  1, 4'd0, 1, 0, 5'd0);
        vecs[8]  = mk(0, 4'd0, 32'h0, 0, 0, 0, W_LW,  1, 4'd0, 1, 0, 5'd0);
        vecs[9]  = mk(0, 4'd0, 32'h0, 0, 0, 0, W_LW,  1, 4'd0, 1, 0, 5'd0);
        vecs[10] = mk(0, 4'd0, 32'h0, 0, 0, 0, W_LW,  1, 4'd0, 1, 0, 5'd0);
        vecs[11] = mk(0, 4'd0, 32'h0, 0, 0, 1, W_ADD, 1, 4'd1, 1, 0, 5'd1);
        vecs[12] = mk(0, 4'd0, 32'h0, 0, 0, 0, W_ADD, 1, 4'd1, 1, 0, 5'd1);
        vecs[13] = mk(0, 4'd0, 32'h0, 0, 0, 1, W_ADD, 0, 4'd2, 0, 1, 5'd2);
        // Load to addr 0 together with start: new word is fetched
        vecs[14] = mk(1, 4'd0, W_INC, 1, 0, 0, W_INC, 1, 4'd0, 1, 0, 5'd0);
        vecs[15] = mk(0, 4'd0, 32'h0, 0, 0, 1, W_ADD, 1, 4'd1, 1, 0, 5'd1);
        // Abort with ready high: transfer not counted
        vecs[16] = mk(0, 4'd0, 32'h0, 0, 1, 1, 32'h0, 0, 4'd0, 0, 0, 5'd1);
        vecs[17] = mk(0, 4'd0, 32'h0, 1, 0, 0, W_INC, 1, 4'd0, 1, 0, 5'd0);
        vecs[18] = mk(0, 4'd0, 32'h0, 0, 1, 0, 32'h0, 0, 4'd0, 0, 0, 5'd0);
        // mem[0] = HALT: straight to HALT, never valid
        vecs[19] = mk(1, 4'd0, 32'h0, 0, 0, 1, 32'h0, 0, 4'd0, 0, 0, 5'd0);
        vecs[20] = mk(0, 4'd0, 32'h0, 1, 0, 1, 32'h0, 0, 4'd0, 0, 1, 5'd0);
        vecs[21] = mk(0, 4'd0, 32'h0, 0, 0, 1, 32'h0, 0, 4'd0, 0, 1, 5'd0);

        #2;
        check_out("reset_hold", 32'h0, 0, 4'd0, 0, 0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("after_reset", 32'h0, 0, 4'd0, 0, 0, 5'd0);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].ld, vecs[i].la, vecs[i].ldat, vecs[i].st, vecs[i].ab, vecs[i].rdy);
            check_out($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_pc,
                      vecs[i].e_busy, vecs[i].e_done, vecs[i].e_issued);
        end

        // Fill all 16 words, run to the end; a load mid-run must be ignored
        for (int a = 0; a < 16; a++) begin
            drive(1, 4'(a), W_ADD, 0, 0, 0);
        end
        drive(0, 4'd0, 32'h0, 1, 0, 1);
        for (int k = 0; k < 16; k++) begin
            check_out($sformatf("fill_pc%0d", k), W_ADD, 1, 4'(k), 1, 0, 5'(k));
            drive((k == 5), 4'd3, 32'hDEAD_BEEF, 0, 0, 1);
        end
        check_out("fill_end", W_ADD, 0, 4'd15, 0, 1, 5'd16);
        drive(0, 4'd0, 32'h0, 0, 0, 1);
        check_out("fill_no_wrap", W_ADD, 0, 4'd15, 0, 1, 5'd16);

        // Readback run: every word, including addr 3, must still be ADD
        drive(0, 4'd0, 32'h0, 1, 0, 1);
        for (int k = 0; k < 16; k++) begin
            check_out($sformatf("readback%0d", k), W_ADD, 1, 4'(k), 1, 0, 5'(k));
            drive(0, 4'd0, 32'h0, 0, 0, 1);
        end
        check_out("readback_end", W_ADD, 0, 4'd15, 0, 1, 5'd16);

        // Asynchronous reset between edges while running and stalled
        drive(0, 4'd0, 32'h0, 1, 0, 0);
        check_out("pre_async", W_ADD, 1, 4'd0, 1, 0, 5'd0);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_reset", 32'h0, 0, 4'd0, 0, 0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 4'd0, 32'h0, 0, 0, 1);
        check_out("post_reset_idle", 32'h0, 0, 4'd0, 0, 0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got time=%0t want finish", $time);
        $fatal(1);
    end

endmodule
